snd_frame_ctrl: RTL and testbench
=================================

Name: snd_frame_ctrl

Overview:
Sequencer for the sound-command byte capture buffer (4-deep shift FIFO with wr/aclr/w_data inputs and full-strobe rd_ena output).
- Hunts the sync byte in the incoming byte stream and forwards exactly FRAME_LEN payload bytes into the buffer.
- Clears the buffer on sync and on error.
- Waits for the buffer's full strobe and reports frame completion or error to the LPC/sound control logic.

Parameters:
FRAME_LEN, 4, payload bytes per frame (1..15)
SYNC_BYTE, 8'hFF, frame start marker
TO_CYCLES, 1024, inter-byte timeout in clk cycles (>=2)
CW, 10, timeout counter width; must satisfy 2^CW >= TO_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-low
byte_vld  in  1  one-cycle strobe, byte_data valid
byte_data  in  8  incoming stream byte
fifo_wr  out  1  write strobe to capture buffer
fifo_wdata  out  8  data to capture buffer
fifo_aclr  out  1  one-cycle clear to capture buffer
fifo_rd_ena  in  1  capture buffer full/complete strobe
frame_done  out  1  one-cycle pulse, frame accepted
frame_err  out  1  one-cycle pulse, frame aborted
busy  out  1  high in any state except IDLE
state  out  2  current state code, for debug

Behaviour:
- Single clock domain. reset==0 at a rising clk edge resets the block:
  - state=IDLE, byte count=0, timer=0.
  - All outputs 0: fifo_wr, fifo_wdata=8'h00, fifo_aclr, frame_done, frame_err, busy.
  - Reset mid-frame discards the frame; no err pulse.
- All outputs are registered. Action on input at edge N appears at edge N+1.
- States (code):
  - IDLE(0):
    - byte_vld && byte_data==SYNC_BYTE -> COLLECT; fifo_aclr=1 next cycle; count=0; timer=0.
    - Other bytes are ignored.
  - COLLECT(1):
    - byte_vld -> fifo_wr=1, fifo_wdata=byte_data next cycle; count+1; timer=0.
    - SYNC_BYTE is treated as payload here.
    - When count reaches FRAME_LEN -> WAIT_ACK.
    - No byte: timer+1. At timer==TO_CYCLES-1 -> ABORT.
  - WAIT_ACK(2):
    - fifo_rd_ena=1 -> frame_done=1 next cycle; -> IDLE.
    - Timer runs (no reset by bytes). At timer==TO_CYCLES-1 -> ABORT.
    - byte_vld here: byte is dropped, no fifo_wr.
  - ABORT(3):
    - One cycle only: fifo_aclr=1, frame_err=1 next cycle; -> IDLE.
- Simultaneous events:
  - fifo_rd_ena and timeout in the same cycle of WAIT_ACK: done wins.
  - byte_vld on the timeout cycle in COLLECT: byte wins, timer cleared.
- fifo_wr is never asserted in IDLE, WAIT_ACK or ABORT.
- fifo_aclr and fifo_wr are never high in the same cycle.
- Counter widths: count is 4 bits. The timer saturates and never wraps.
- Back-to-back: a sync byte arriving the same cycle as IDLE entry is honoured the next cycle only. Bytes during WAIT_ACK/ABORT are dropped.

Optional Feature:
SND_FRAME_CKSUM_EN:
- Defined:
  - A frame is FRAME_LEN payload bytes plus one checksum byte.
  - An 8-bit running sum (mod 256) is kept over the payload only.
  - The checksum byte is not forwarded (no fifo_wr).
  - Match -> WAIT_ACK.
  - Mismatch -> ABORT (fifo_aclr + frame_err).
- Undefined: no checksum byte, no sum logic. The FRAME_LEN-th byte goes directly to WAIT_ACK.

Test Plan:
- Reset low 3 cycles while byte_vld toggles -> all outputs 0, state=0.
- Bytes FF,11,22,33,44; fifo_rd_ena pulsed 2 cycles after the last fifo_wr:
  - fifo_aclr once.
  - 4 fifo_wr with data 11,22,33,44.
  - frame_done once; state returns to 0.
- FF,12 then idle 1024 cycles -> 1 fifo_wr (12), then frame_err + fifo_aclr pulse; state 3 -> 0.
- Stray bytes 00,A5 in IDLE, then FF,FF,FF,FF,FF -> 00,A5 ignored; payload FF,FF,FF,FF forwarded; no second aclr.
- Full frame, then fifo_rd_ena held low for TO_CYCLES -> frame_err, no frame_done.
- Full frame with fifo_rd_ena asserted on the timeout cycle -> frame_done only.
- With SND_FRAME_CKSUM_EN: FF,01,02,03,04,0A -> frame_done. FF,01,02,03,04,0B -> frame_err + aclr; checksum byte never written in either case.

Source files
------------

// File: rtl/snd_frame_ctrl.sv
// snd_frame_ctrl: hunts SYNC_BYTE, forwards FRAME_LEN payload bytes into the capture FIFO, waits for its full strobe.
// Define SND_FRAME_CKSUM_EN to require a trailing mod-256 checksum byte (not forwarded) after the payload.
module snd_frame_ctrl #(
  parameter int         FRAME_LEN = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hFF,
  parameter int         TO_CYCLES = 1024,
  parameter int         CW        = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_vld,
  input  logic [7:0] byte_data,
  output logic       fifo_wr,
  output logic [7:0] fifo_wdata,
  output logic       fifo_aclr,
  input  logic       fifo_rd_ena,
  output logic       frame_done,
  output logic       frame_err,
  output logic       busy,
  output logic [1:0] state
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COLLECT  = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] ABORT    = 2'd3;

  localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYCLES - 1);
  localparam logic [3:0]    LEN      = 4'(FRAME_LEN);
  localparam logic [3:0]    LEN_LAST = 4'(FRAME_LEN - 1);

  logic [3:0]    count;
  logic [CW-1:0] timer;
  logic          timed_out;

`ifdef SND_FRAME_CKSUM_EN
  logic [7:0] sum;
`endif

  // The timer never increments past TO_LAST: reaching it always leaves the state.
  assign timed_out = (timer == TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      timer      <= '0;
      fifo_wr    <= 1'b0;
      fifo_wdata <= 8'h00;
      fifo_aclr  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef SND_FRAME_CKSUM_EN
      sum        <= 8'h00;
`endif
    end else begin
      fifo_wr    <= 1'b0;
      fifo_aclr  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (byte_vld && byte_data == SYNC_BYTE) begin
            state     <= COLLECT;
            busy      <= 1'b1;
            fifo_aclr <= 1'b1;
            count     <= 4'd0;
            timer     <= '0;
`ifdef SND_FRAME_CKSUM_EN
            sum       <= 8'h00;
`endif
          end
        end
        COLLECT: begin
          if (byte_vld) begin
            timer <= '0;
`ifdef SND_FRAME_CKSUM_EN
            // Once the payload is complete the next byte is the checksum.
            if (count == LEN) begin
              state <= (byte_data == sum) ? WAIT_ACK : ABORT;
            end else begin
              fifo_wr    <= 1'b1;
              fifo_wdata <= byte_data;
              count      <= count + 4'd1;
              sum        <= sum + byte_data;
            end
`else
            fifo_wr    <= 1'b1;
            fifo_wdata <= byte_data;
            count      <= count + 4'd1;
            if (count == LEN_LAST) begin
              state <= WAIT_ACK;
            end
`endif
          end else if (timed_out) begin
            state <= ABORT;
          end else begin
            timer <= timer + CW'(1);
          end
        end
        WAIT_ACK: begin
          // Full strobe beats a simultaneous timeout.
          if (fifo_rd_ena) begin
            frame_done <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end else if (timed_out) begin
            state <= ABORT;
          end else begin
            timer <= timer + CW'(1);
          end
        end
        default: begin
          fifo_aclr <= 1'b1;
          frame_err <= 1'b1;
          state     <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snd_frame_ctrl.sv
// tb_snd_frame_ctrl: directed frames checked every cycle against a queue-based frame model plus literal event counts.
// Honours SND_FRAME_CKSUM_EN the same way as the design.
module tb_snd_frame_ctrl;

  localparam int FL = 4;
  localparam int TO = 1024;
`ifdef SND_FRAME_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       byte_vld = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       fifo_rd_ena = 1'b0;
  logic       fifo_wr, fifo_aclr, frame_done, frame_err, busy;
  logic [7:0] fifo_wdata;
  logic [1:0] state;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: phase follows the specified state codes, payload bytes live in a queue.
  int         m_phase = 0;
  int         m_quiet = 0;
  logic [7:0] m_payload[$];
  logic       m_wr = 1'b0, m_aclr = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [7:0] m_wdata = 8'h00;
  bit         m_valid = 1'b0;

  int         wr_cnt = 0, aclr_cnt = 0, done_cnt = 0, err_cnt = 0;
  bit         seen_abort = 1'b0;
  logic [7:0] wr_log[$];

  snd_frame_ctrl #(
    .FRAME_LEN(FL), .SYNC_BYTE(8'hFF), .TO_CYCLES(TO), .CW(10)
  ) dut (
    .clk(clk), .reset(reset), .byte_vld(byte_vld), .byte_data(byte_data),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_aclr(fifo_aclr),
    .fifo_rd_ena(fifo_rd_ena), .frame_done(frame_done), .frame_err(frame_err),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sum_of(input logic [7:0] q[$]);
    logic [7:0] s;
    s = 8'h00;
    foreach (q[i]) s = s + q[i];
    return s;
  endfunction

  task automatic model_step();
    m_wr = 1'b0; m_aclr = 1'b0; m_done = 1'b0; m_err = 1'b0;
    if (!reset) begin
      m_phase = 0; m_wdata = 8'h00; m_quiet = 0; m_payload.delete();
    end else begin
      case (m_phase)
        0: if (byte_vld && byte_data == 8'hFF) begin
             m_phase = 1; m_aclr = 1'b1; m_quiet = 0; m_payload.delete();
           end
        1: if (byte_vld) begin
             m_quiet = 0;
             if (CK && m_payload.size() == FL) begin
               m_phase = (byte_data == sum_of(m_payload)) ? 2 : 3;
             end else begin
               m_wr = 1'b1; m_wdata = byte_data; m_payload.push_back(byte_data);
               if (!CK && m_payload.size() == FL) m_phase = 2;
             end
           end else begin
             m_quiet++;
             if (m_quiet == TO) m_phase = 3;
           end
        2: if (fifo_rd_ena) begin
             m_done = 1'b1; m_phase = 0;
           end else begin
             m_quiet++;
             if (m_quiet == TO) m_phase = 3;
           end
        default: begin
          m_aclr = 1'b1; m_err = 1'b1; m_phase = 0;
        end
      endcase
    end
    m_valid = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output plus event bookkeeping for the literal checks.
  initial forever begin
    logic [14:0] act, expv;
    @(negedge clk);
    if (m_valid) begin
      act  = {fifo_wr, fifo_wdata, fifo_aclr, frame_done, frame_err, busy, state};
      expv = {m_wr, m_wdata, m_aclr, m_done, m_err, (m_phase != 0), 2'(m_phase)};
      n_cmp++;
      if (act !== expv) begin
        n_fail++;
        $display("[TB] FAIL cycle_outputs t=%0t actual=%h required=%h", $time, act, expv);
      end
    end
    if (fifo_wr === 1'b1) begin wr_cnt++; wr_log.push_back(fifo_wdata); end
    if (fifo_aclr === 1'b1) aclr_cnt++;
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (state === 2'd3) seen_abort = 1'b1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    byte_vld = v; byte_data = d; fifo_rd_ena = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3);
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, p0, 1'b0);
    cycle(1'b1, p1, 1'b0);
    cycle(1'b1, p2, 1'b0);
    cycle(1'b1, p3, 1'b0);
    if (CK) cycle(1'b1, p0 + p1 + p2 + p3, 1'b0);
  endtask

  task automatic clear_counts();
    wr_cnt = 0; aclr_cnt = 0; done_cnt = 0; err_cnt = 0;
    seen_abort = 1'b0; wr_log.delete();
  endtask

  function automatic logic [31:0] log_word();
    if (wr_log.size() != 4) return 32'h0;
    return {wr_log[0], wr_log[1], wr_log[2], wr_log[3]};
  endfunction

  initial begin
    $display("[TB] start, checksum=%0d", CK);
    // Reset held low for three edges while byte_vld toggles.
    for (int i = 0; i < 3; i++) cycle(1'(i % 2), 8'hFF, 1'b0);
    @(negedge clk);
    check_output("reset_outputs", {22'd0, fifo_wr, fifo_wdata, fifo_aclr, frame_done, frame_err, busy},
                 32'd0);
    check_output("reset_state", {30'd0, state}, 32'd0);
    reset = 1'b1; byte_vld = 1'b0;

    // Basic frame, ack two cycles after the last write.
    clear_counts();
    send_frame(8'h11, 8'h22, 8'h33, 8'h44);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    idle(3);
    check_output("basic_aclr", aclr_cnt, 1);
    check_output("basic_wr", wr_cnt, 4);
    check_output("basic_data", log_word(), 32'h11223344);
    check_output("basic_done", done_cnt, 1);
    check_output("basic_state", {30'd0, state}, 32'd0);

    // Inter-byte timeout in COLLECT.
    clear_counts();
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    idle(TO + 4);
    check_output("to_wr", wr_cnt, 1);
    check_output("to_wr_data", {24'd0, wr_log.size() > 0 ? wr_log[0] : 8'h00}, 32'h12);
    check_output("to_err", err_cnt, 1);
    check_output("to_aclr", aclr_cnt, 2);
    check_output("to_abort_seen", {31'd0, seen_abort}, 32'd1);
    check_output("to_state", {30'd0, state}, 32'd0);

    // Stray bytes in IDLE, sync bytes as payload.
    clear_counts();
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0);
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    idle(2);
    check_output("stray_aclr", aclr_cnt, 1);
    check_output("stray_data", log_word(), 32'hFFFFFFFF);
    check_output("stray_done", done_cnt, 1);

    // No ack: WAIT_ACK timeout.
    clear_counts();
    send_frame(8'h01, 8'h02, 8'h03, 8'h04);
    idle(TO + 3);
    check_output("ack_to_err", err_cnt, 1);
    check_output("ack_to_done", done_cnt, 0);

    // Ack on the timeout cycle wins.
    clear_counts();
    send_frame(8'h05, 8'h06, 8'h07, 8'h08);
    idle(TO - 1);
    cycle(1'b0, 8'h00, 1'b1);
    idle(2);
    check_output("ack_edge_done", done_cnt, 1);
    check_output("ack_edge_err", err_cnt, 0);

    // Byte on the COLLECT timeout cycle wins; sync with ack is dropped.
    clear_counts();
    cycle(1'b1, 8'hFF, 1'b0);
    idle(TO - 1);
    cycle(1'b1, 8'hA1, 1'b0);
    cycle(1'b1, 8'hA2, 1'b0);
    cycle(1'b1, 8'hA3, 1'b0);
    cycle(1'b1, 8'hA4, 1'b0);
    if (CK) cycle(1'b1, 8'h8A, 1'b0);
    cycle(1'b1, 8'hFF, 1'b1);
    idle(2);
    check_output("byte_edge_err", err_cnt, 0);
    check_output("byte_edge_data", log_word(), 32'hA1A2A3A4);
    check_output("b2b_aclr", aclr_cnt, 1);
    check_output("b2b_state", {30'd0, state}, 32'd0);

    // Mid-frame reset discards silently.
    clear_counts();
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'h11, 1'b0);
    @(negedge clk);
    byte_vld = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    check_output("midreset_err", err_cnt, 0);
    check_output("midreset_state", {30'd0, state}, 32'd0);

`ifdef SND_FRAME_CKSUM_EN
    clear_counts();
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    cycle(1'b1, 8'h04, 1'b0);
    cycle(1'b1, 8'h0A, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    idle(2);
    check_output("ck_good_done", done_cnt, 1);
    check_output("ck_good_wr", wr_cnt, 4);
    check_output("ck_good_data", log_word(), 32'h01020304);

    clear_counts();
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    cycle(1'b1, 8'h03, 1'b0);
    cycle(1'b1, 8'h04, 1'b0);
    cycle(1'b1, 8'h0B, 1'b0);
    idle(3);
    check_output("ck_bad_err", err_cnt, 1);
    check_output("ck_bad_aclr", aclr_cnt, 2);
    check_output("ck_bad_wr", wr_cnt, 4);
    check_output("ck_bad_done", done_cnt, 0);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
